// File: rtl/rgb2gray_share_arb.sv
// rgb2gray_share_arb
//   Shares one rgb2gray datapath between two RGB pixel sources, granting whole
//   lines round-robin. The returned gray stream is re-tagged with the source id
//   and a last-of-line flag. Lines that reach MAX_LINE pixels without a last flag
//   are force-released.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   s0_valid/s0_ready/s0_last  source 0 handshake and last-of-line flag
//   s0_r/s0_g/s0_b             source 0 colour components
//   s1_*                       same set for source 1
//   dp_din_valid, dp_r/g/b     drive the shared rgb2gray datapath input
//   dp_dout_valid, dp_gray     results returned by the rgb2gray datapath
//   gray_valid/data/src/last   tagged gray output, valid for one cycle
//   line_ovf                   one-cycle pulse when a line was force-released
//   tag_err                    sticky flag: dp_dout_valid disagreed with the tag pipe
module rgb2gray_share_arb #(
   parameter int unsigned GRAY_LAT = 2,
   parameter int unsigned MAX_LINE = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s0_valid,
   output logic       s0_ready,
   input  logic       s0_last,
   input  logic [7:0] s0_r,
   input  logic [7:0] s0_g,
   input  logic [7:0] s0_b,
   input  logic       s1_valid,
   output logic       s1_ready,
   input  logic       s1_last,
   input  logic [7:0] s1_r,
   input  logic [7:0] s1_g,
   input  logic [7:0] s1_b,
   output logic       dp_din_valid,
   output logic [7:0] dp_r,
   output logic [7:0] dp_g,
   output logic [7:0] dp_b,
   input  logic       dp_dout_valid,
   input  logic [7:0] dp_gray,
   output logic       gray_valid,
   output logic [7:0] gray_data,
   output logic       gray_src,
   output logic       gray_last,
   output logic       line_ovf,
   output logic       tag_err
);

   localparam int unsigned CW = $clog2(MAX_LINE + 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StG0   = 2'd1;
   localparam logic [1:0] StG1   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          rr_last_q, rr_last_d;
   logic [CW-1:0] count_q, count_d;

   // Tag pipe: index 0 is aligned with dp_din_valid, index GRAY_LAT with dp_dout_valid.
   logic [GRAY_LAT:0] tag_v_q, tag_s_q, tag_l_q;

   logic sel;
   logic xfer;
   logic cur_last;
   logic own_valid;
   logic other_valid;
   logic at_max;
   logic forced;
   logic line_end;

   assign s0_ready = (state_q == StG0);
   assign s1_ready = (state_q == StG1);

   always_comb begin
      sel         = (state_q == StG1);
      xfer        = ((state_q == StG0) && s0_valid) || ((state_q == StG1) && s1_valid);
      cur_last    = sel ? s1_last : s0_last;
      own_valid   = sel ? s1_valid : s0_valid;
      other_valid = sel ? s0_valid : s1_valid;
      at_max      = (count_q == CW'(MAX_LINE - 1));
      forced      = xfer && !cur_last && at_max;
      line_end    = xfer && (cur_last || at_max);
   end

   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      count_d   = count_q;
      case (state_q)
         StIdle: begin
            if (s0_valid || s1_valid) begin
               // The source that was not served last has priority.
               if (rr_last_q) state_d = s0_valid ? StG0 : StG1;
               else           state_d = s1_valid ? StG1 : StG0;
            end
         end
         StG0, StG1: begin
            if (xfer) count_d = count_q + CW'(1);
            if (line_end) begin
               count_d   = '0;
               rr_last_d = sel;
               if (other_valid)    state_d = sel ? StG0 : StG1;
               else if (own_valid) state_d = state_q;
               else                state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         rr_last_q <= 1'b1;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         count_q   <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_din_valid <= 1'b0;
         dp_r         <= '0;
         dp_g         <= '0;
         dp_b         <= '0;
      end else begin
         dp_din_valid <= xfer;
         if (xfer) begin
            dp_r <= sel ? s1_r : s0_r;
            dp_g <= sel ? s1_g : s0_g;
            dp_b <= sel ? s1_b : s0_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v_q <= '0;
         tag_s_q <= '0;
         tag_l_q <= '0;
      end else begin
         tag_v_q <= {tag_v_q[GRAY_LAT-1:0], xfer};
         tag_s_q <= {tag_s_q[GRAY_LAT-1:0], xfer && sel};
         tag_l_q <= {tag_l_q[GRAY_LAT-1:0], xfer && (cur_last || forced)};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_valid <= 1'b0;
         gray_data  <= '0;
         gray_src   <= 1'b0;
         gray_last  <= 1'b0;
         line_ovf   <= 1'b0;
         tag_err    <= 1'b0;
      end else begin
         gray_valid <= dp_dout_valid;
         gray_data  <= dp_gray;
         gray_src   <= tag_s_q[GRAY_LAT];
         gray_last  <= tag_l_q[GRAY_LAT];
         line_ovf   <= forced;
         tag_err    <= tag_err || (dp_dout_valid != tag_v_q[GRAY_LAT]);
      end
   end

endmodule

// File: tb/tb_rgb2gray_share_arb.sv
// Bench for rgb2gray_share_arb: directed scenarios plus randomized line traffic,
// checked every cycle against a transaction-level model of line arbitration.
module tb_rgb2gray_share_arb;

   localparam int unsigned GL  = 2;
   localparam int unsigned ML  = 4;
   localparam int          LAT = GL + 2;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       last;
   } pix_t;

   logic       clk, rst_n;
   logic       s0_valid, s0_ready, s0_last, s1_valid, s1_ready, s1_last;
   logic [7:0] s0_r, s0_g, s0_b, s1_r, s1_g, s1_b;
   logic       dp_din_valid, dp_dout_valid;
   logic [7:0] dp_r, dp_g, dp_b, dp_gray;
   logic       gray_valid, gray_src, gray_last, line_ovf, tag_err;
   logic [7:0] gray_data;
   logic       inject;

   rgb2gray_share_arb #(.GRAY_LAT(GL), .MAX_LINE(ML)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_last(s0_last),
      .s0_r(s0_r), .s0_g(s0_g), .s0_b(s0_b),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_last(s1_last),
      .s1_r(s1_r), .s1_g(s1_g), .s1_b(s1_b),
      .dp_din_valid(dp_din_valid), .dp_r(dp_r), .dp_g(dp_g), .dp_b(dp_b),
      .dp_dout_valid(dp_dout_valid), .dp_gray(dp_gray),
      .gray_valid(gray_valid), .gray_data(gray_data), .gray_src(gray_src),
      .gray_last(gray_last), .line_ovf(line_ovf), .tag_err(tag_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gray_fn(logic [7:0] r, logic [7:0] g, logic [7:0] b);
      int s;
      s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
      return 8'(s >> 8);
   endfunction

   // rgb2gray stand-in: fixed GL-cycle latency, plus an injectable spurious valid.
   logic [GL-1:0] pv;
   logic [7:0]    pd [GL];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv <= '0;
      end else begin
         pv[0] <= dp_din_valid;
         pd[0] <= gray_fn(dp_r, dp_g, dp_b);
         for (int i = 1; i < GL; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
      end
   end
   assign dp_dout_valid = pv[GL-1] | inject;
   assign dp_gray       = pd[GL-1];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pct0 = 100, pct1 = 100;
   pix_t q0[$], q1[$];

   // Model: owner -1 = nobody, else the source holding the line grant.
   int owner, rr_last, cnt, err_cyc;
   bit         e_v[16], e_dc[16], e_s[16], e_l[16], e_ovf[16], e_din[16];
   logic [7:0] e_d[16], e_r[16], e_g[16], e_b[16];

   int   obs_cyc[$];
   logic [7:0] obs_d[$];
   bit   obs_s[$], obs_l[$];
   int   hs0_cnt, hs1_cnt, first_hs0, s1_at_s0_last, ovf_cnt;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      owner = -1; rr_last = 1; cnt = 0; err_cyc = 32'h3fff_ffff;
      for (int i = 0; i < 16; i++) begin
         e_v[i] = 0; e_dc[i] = 0; e_ovf[i] = 0; e_din[i] = 0;
      end
   endtask

   task automatic clear_obs();
      obs_cyc.delete(); obs_d.delete(); obs_s.delete(); obs_l.delete();
      hs0_cnt = 0; hs1_cnt = 0; first_hs0 = -1; s1_at_s0_last = -1; ovf_cnt = 0;
   endtask

   task automatic push_pix(input int src, input int r, input int g, input int b, input bit last);
      pix_t p;
      p.r = 8'(r); p.g = 8'(g); p.b = 8'(b); p.last = last;
      if (src == 1) q1.push_back(p); else q0.push_back(p);
   endtask

   task automatic push_line(input int src, input int len);
      for (int i = 0; i < len; i++)
         push_pix(src, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  i == len - 1);
   endtask

   task automatic model_step();
      pix_t p;
      bit v0, v1, vk, vo, forced;
      int n;
      v0 = s0_valid; v1 = s1_valid;
      if (owner < 0) begin
         if (v0 || v1) owner = (rr_last == 1) ? (v0 ? 0 : 1) : (v1 ? 1 : 0);
      end else begin
         vk = (owner == 1) ? v1 : v0;
         vo = (owner == 1) ? v0 : v1;
         if (vk) begin
            p = (owner == 1) ? {s1_r, s1_g, s1_b, s1_last} : {s0_r, s0_g, s0_b, s0_last};
            cnt++;
            forced = !p.last && (cnt == ML);
            n = (cyc + 1) % 16;
            e_din[n] = 1; e_r[n] = p.r; e_g[n] = p.g; e_b[n] = p.b;
            n = (cyc + LAT) % 16;
            e_v[n] = 1; e_dc[n] = 0; e_d[n] = gray_fn(p.r, p.g, p.b);
            e_s[n] = (owner == 1); e_l[n] = p.last || forced;
            if (p.last || forced) begin
               if (forced) e_ovf[(cyc + 1) % 16] = 1;
               cnt = 0;
               rr_last = owner;
               owner = vo ? 1 - owner : owner;
            end
         end
      end
   endtask

   // One clock cycle: drive at the falling edge, compare, advance model, cross the rising edge.
   task automatic tick();
      int slot;
      if (q0.size() > 0 && $urandom_range(0, 99) < pct0) begin
         s0_valid = 1'b1; {s0_r, s0_g, s0_b, s0_last} = q0[0];
      end else begin
         s0_valid = 1'b0; {s0_r, s0_g, s0_b, s0_last} = 25'($urandom);
      end
      if (q1.size() > 0 && $urandom_range(0, 99) < pct1) begin
         s1_valid = 1'b1; {s1_r, s1_g, s1_b, s1_last} = q1[0];
      end else begin
         s1_valid = 1'b0; {s1_r, s1_g, s1_b, s1_last} = 25'($urandom);
      end
      #1;
      slot = cyc % 16;
      chk("s0_ready", s0_ready, owner == 0);
      chk("s1_ready", s1_ready, owner == 1);
      chk("gray_valid", gray_valid, e_v[slot]);
      if (e_v[slot] && !e_dc[slot]) begin
         chk("gray_data", gray_data, e_d[slot]);
         chk("gray_src", gray_src, e_s[slot]);
         chk("gray_last", gray_last, e_l[slot]);
      end
      chk("line_ovf", line_ovf, e_ovf[slot]);
      chk("tag_err", tag_err, cyc >= err_cyc);
      chk("dp_din_valid", dp_din_valid, e_din[slot]);
      if (e_din[slot]) begin
         chk("dp_r", dp_r, e_r[slot]);
         chk("dp_g", dp_g, e_g[slot]);
         chk("dp_b", dp_b, e_b[slot]);
      end
      if (gray_valid) begin
         obs_cyc.push_back(cyc); obs_d.push_back(gray_data);
         obs_s.push_back(gray_src); obs_l.push_back(gray_last);
      end
      if (line_ovf) ovf_cnt++;
      e_v[slot] = 0; e_dc[slot] = 0; e_ovf[slot] = 0; e_din[slot] = 0;
      model_step();
      if (s0_valid && s0_ready) begin
         if (hs0_cnt == 0) first_hs0 = cyc;
         hs0_cnt++;
         if (s0_last) s1_at_s0_last = hs1_cnt;
         void'(q0.pop_front());
      end
      if (s1_valid && s1_ready) begin
         hs1_cnt++;
         void'(q1.pop_front());
      end
      @(posedge clk);
      #1 inject = 1'b0;
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_until_empty(input int bound, input int drain);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < bound) begin
         tick();
         n++;
      end
      if (q0.size() > 0 || q1.size() > 0) chk("drain_timeout", q0.size() + q1.size(), 0);
      repeat (drain) tick();
   endtask

   // Called at a falling edge; asserts reset and checks outputs clear within the cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      s0_valid = 1'b0; s1_valid = 1'b0;
      #1;
      chk("rst_s0_ready", s0_ready, 0);
      chk("rst_s1_ready", s1_ready, 0);
      chk("rst_dp_din_valid", dp_din_valid, 0);
      chk("rst_dp_rgb", {dp_r, dp_g, dp_b}, 0);
      chk("rst_gray_valid", gray_valid, 0);
      chk("rst_gray_data", gray_data, 0);
      chk("rst_gray_src", gray_src, 0);
      chk("rst_gray_last", gray_last, 0);
      chk("rst_line_ovf", line_ovf, 0);
      chk("rst_tag_err", tag_err, 0);
      model_reset();
      q0.delete(); q1.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_src[8];
      int exp_last[8];
      rst_n = 1'b0; inject = 1'b0;
      s0_valid = 0; s0_last = 0; s0_r = 0; s0_g = 0; s0_b = 0;
      s1_valid = 0; s1_last = 0; s1_r = 0; s1_g = 0; s1_b = 0;
      model_reset();
      clear_obs();
      @(negedge clk);
      do_reset();

      // Single s0 line of three pixels.
      push_pix(0, 255, 255, 255, 0);
      push_pix(0, 0, 0, 0, 0);
      push_pix(0, 128, 128, 128, 1);
      run_until_empty(50, 8);
      chk("a_count", obs_d.size(), 3);
      if (obs_d.size() == 3) begin
         chk("a_gray0", obs_d[0], 255);
         chk("a_gray1", obs_d[1], 0);
         chk("a_gray2", obs_d[2], 128);
         chk("a_src", {obs_s[0], obs_s[1], obs_s[2]}, 0);
         chk("a_last", {obs_l[0], obs_l[1], obs_l[2]}, 1);
         chk("a_latency", obs_cyc[0] - first_hs0, 4);
      end

      // Both sources valid from reset: s0, s1, s0 lines back to back.
      @(negedge clk);
      do_reset();
      clear_obs();
      push_line(0, 2); push_line(0, 2); push_line(1, 2);
      run_until_empty(50, 8);
      exp_src = '{0, 0, 1, 1, 0, 0, 0, 0};
      chk("b_count", obs_d.size(), 6);
      if (obs_d.size() == 6) begin
         for (int i = 0; i < 6; i++) chk("b_src", obs_s[i], exp_src[i]);
         chk("b_no_bubble", obs_cyc[5] - obs_cyc[0], 5);
      end

      // s0 stalls mid-line while s1 waits.
      @(negedge clk);
      do_reset();
      clear_obs();
      push_pix(0, 10, 20, 30, 0);
      push_line(1, 2);
      while (q0.size() > 0 && cyc < 90000) tick();
      repeat (3) tick();
      push_pix(0, 40, 50, 60, 0);
      push_pix(0, 70, 80, 90, 1);
      run_until_empty(50, 8);
      chk("c_s1_before_s0_last", s1_at_s0_last, 0);
      chk("c_s1_count", hs1_cnt, 2);

      // Over-long s0 line with s1 waiting.
      @(negedge clk);
      do_reset();
      clear_obs();
      for (int i = 0; i < 6; i++) push_pix(0, i * 40, i * 30, i * 20, 0);
      push_line(1, 2);
      run_until_empty(50, 8);
      exp_src  = '{0, 0, 0, 0, 1, 1, 0, 0};
      exp_last = '{0, 0, 0, 1, 0, 1, 0, 0};
      chk("d_count", obs_d.size(), 8);
      if (obs_d.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("d_src", obs_s[i], exp_src[i]);
            chk("d_last", obs_l[i], exp_last[i]);
         end
      end
      chk("d_ovf_pulses", ovf_cnt, 1);

      // Reset in the middle of the open s0 line with pixels in flight.
      push_pix(0, 1, 2, 3, 0);
      tick();
      do_reset();
      clear_obs();
      repeat (6) tick();
      chk("e_no_stale", obs_d.size(), 0);
      push_line(1, 1);
      push_line(0, 1);
      tick();
      chk("e_grant_s0", s0_ready, 1);
      chk("e_grant_s1", s1_ready, 0);
      run_until_empty(50, 8);

      // Randomized traffic with stalls and occasional over-long lines.
      @(negedge clk);
      do_reset();
      clear_obs();
      pct0 = $urandom_range(50, 100);
      pct1 = $urandom_range(50, 100);
      repeat (3000) begin
         if (q0.size() < 4 && $urandom_range(0, 3) == 0) push_line(0, $urandom_range(1, 7));
         if (q1.size() < 4 && $urandom_range(0, 3) == 0) push_line(1, $urandom_range(1, 7));
         tick();
      end
      pct0 = 100; pct1 = 100;
      run_until_empty(500, 10);

      // Spurious dp_dout_valid sets the sticky tag error.
      inject = 1'b1;
      e_v[(cyc + 1) % 16] = 1;
      e_dc[(cyc + 1) % 16] = 1;
      err_cyc = cyc + 1;
      tick();
      repeat (10) tick();
      chk("f_tag_err_sticky", tag_err, 1);
      @(negedge clk);
      do_reset();
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
